mult_result_writeback: RTL
==========================

Name: mult_result_writeback

Overview:
Execute-stage sequencer directly downstream of the 8-bit multiplier. Captures the multiplier's 16-bit product and its flags in one cycle. Writes the product to the 8-bit register file over two consecutive cycles:
- low byte to dest_reg
- high byte to dest_reg+1

Holds busy high so the pipeline stalls until both bytes and the flags are committed.

Parameters:
REG_ADDR_W, 5, register file address width (2^REG_ADDR_W registers)

Ports:
clock  in  1  system clock, all state updates on rising edge
nreset  in  1  reset, synchronous, active-low
start  in  1  multiply issued; product/flags/dest valid this cycle (multiplier oe high)
dest_reg  in  REG_ADDR_W  destination register for the low byte
mult_out  in  16  product from multiplier
flags_in  in  3  multiplier flags: [0] zero, [1] negative, [2] carry
busy  out  1  sequencer occupied; upstream must hold/stall
rf_we  out  1  register file write enable
rf_waddr  out  REG_ADDR_W  register file write address
rf_wdata  out  8  register file write data
flags_we  out  1  status register flag write enable
flags_out  out  3  flags to status register
done  out  1  one-cycle pulse on the high-byte write cycle

Behaviour:
- Reset:
  - Synchronous, active-low.
  - nreset low at a rising edge -> state IDLE; prod_q, flags_q, dest_q cleared to 0.
  - All outputs then read 0.
- States: IDLE, WR_LO, WR_HI. Encoding is free.
- Outputs:
  - Decoded only from state and latched registers; never combinationally from inputs.
  - No glitch path from start to rf_we.
- IDLE:
  - busy=0, rf_we=0, flags_we=0, done=0.
  - rf_waddr, rf_wdata and flags_out = 0.
  - start=1 at an edge -> latch prod_q<=mult_out, flags_q<=flags_in, dest_q<=dest_reg; go to WR_LO.
- WR_LO:
  - busy=1, rf_we=1, rf_waddr=dest_q, rf_wdata=prod_q[7:0], flags_we=0, done=0.
  - Next edge -> WR_HI unconditionally.
- WR_HI:
  - busy=1, rf_we=1, rf_waddr=dest_q+1, rf_wdata=prod_q[15:8].
  - flags_we=1, flags_out=flags_q, done=1.
  - Next edge -> IDLE.
- Address wrap: dest_q+1 is computed modulo 2^REG_ADDR_W (31+1 -> 0 for width 5).
- Latency: start sampled at edge N -> low byte driven during cycle N..N+1, high byte + flags during N+1..N+2; busy deasserts after edge N+2. Throughput: one multiply per 3 cycles.
- start while busy=1 (WR_LO or WR_HI): ignored; no latch, no state change. Upstream must hold start until busy=0.
- start in the IDLE cycle directly after WR_HI: accepted normally. Minimum spacing between accepts is 3 cycles.
- Reset mid-operation:
  - nreset low in WR_LO -> IDLE at that edge; high byte and flags are never written.
  - nreset low in WR_HI -> IDLE; the high write presented that cycle still occurs at that edge only if the register file samples before reset. Verification checks outputs only.
- Simultaneous nreset=0 and start=1: reset wins; nothing latched.
- Flags are passed through unmodified; no recomputation from prod_q.
- Undriven (Z) input bits latched while start=1 are a protocol violation. The bench must never assert start with multiplier oe low.

Optional Feature:
MULT_WB_FWD_EN
- Defined: adds outputs fwd_valid (1), fwd_addr (REG_ADDR_W), fwd_data (8) for pipeline hazard forwarding.
  - In WR_LO: fwd_valid=1, fwd_addr=dest_q+1, fwd_data=prod_q[15:8]. This exposes the not-yet-written high byte.
  - In WR_HI and IDLE: fwd_valid=0, fwd_addr=0, fwd_data=0.
  - Reset clears all three.
- Undefined: ports absent; behaviour otherwise identical.

Test Plan:
1. Basic write: reset, then start=1, dest_reg=4, mult_out=0xABCD, flags_in=3'b010.
   - Next cycle: rf_we=1, addr=4, data=0xCD, busy=1.
   - Following cycle: addr=5, data=0xAB, flags_we=1, flags_out=010, done=1.
   - Then busy=0.
2. Zero product: dest_reg=10, mult_out=0x0000, flags_in=3'b001.
   - Writes 0x00 to 10, then 0x00 to 11.
   - flags_out=001 with done.
3. Address wrap: dest_reg=31, mult_out=0x1234.
   - Writes 0x34 to 31, then 0x12 to 0.
4. Busy protocol:
   - Accept dest_reg=2, mult_out=0x0102.
   - Hold start=1 with dest_reg=7, mult_out=0xFFFF through WR_LO and WR_HI.
   - Required: writes only 0x02@2, 0x01@3.
   - Second request accepted in the next IDLE cycle: 0xFF@7, 0xFF@8 exactly 3 cycles after the first accept.
5. Reset mid-op:
   - Accept dest_reg=6, mult_out=0x5A5A.
   - Drive nreset=0 during WR_LO.
   - Required: state IDLE, all outputs 0, no done pulse, no write to 7, flags_we never asserted.
6. MULT_WB_FWD_EN defined, scenario 1 stimulus:
   - During WR_LO: fwd_valid=1, fwd_addr=5, fwd_data=0xAB.
   - fwd_valid=0 in all other cycles.

Source files
------------

// File: rtl/mult_result_writeback_if.sv
// Bundles the multiplier-side request and the register-file/status writeback signals.
// With MULT_WB_FWD_EN defined, it also carries the high-byte forwarding signals.
interface mult_result_writeback_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic [15:0]           mult_out;
    logic [2:0]            flags_in;
    logic                  busy;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [7:0]            rf_wdata;
    logic                  flags_we;
    logic [2:0]            flags_out;
    logic                  done;
`ifdef MULT_WB_FWD_EN
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_addr;
    logic [7:0]            fwd_data;
`endif

`ifdef MULT_WB_FWD_EN
    modport master (
        output start, dest_reg, mult_out, flags_in,
        input  busy, rf_we, rf_waddr, rf_wdata, flags_we, flags_out, done,
               fwd_valid, fwd_addr, fwd_data
    );
    modport slave (
        input  start, dest_reg, mult_out, flags_in,
        output busy, rf_we, rf_waddr, rf_wdata, flags_we, flags_out, done,
               fwd_valid, fwd_addr, fwd_data
    );
`else
    modport master (
        output start, dest_reg, mult_out, flags_in,
        input  busy, rf_we, rf_waddr, rf_wdata, flags_we, flags_out, done
    );
    modport slave (
        input  start, dest_reg, mult_out, flags_in,
        output busy, rf_we, rf_waddr, rf_wdata, flags_we, flags_out, done
    );
`endif
endinterface

// File: rtl/mult_result_writeback.sv
// Captures a 16-bit product plus flags and writes it into the register file as two
// bytes (low at dest, high at dest+1). Optional MULT_WB_FWD_EN adds high-byte forwarding.
module mult_result_writeback #(
    parameter int REG_ADDR_W = 5
) (
    input logic                    clock,
    input logic                    nreset,
    mult_result_writeback_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    localparam logic [REG_ADDR_W-1:0] ADDR_ONE = 1;

    state_t                state_q;
    state_t                state_d;
    logic [15:0]           prod_q;
    logic [2:0]            flags_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [REG_ADDR_W-1:0] dest_inc;

    logic                  busy;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [7:0]            rf_wdata;
    logic                  flags_we;
    logic [2:0]            flags_out;
    logic                  done;
`ifdef MULT_WB_FWD_EN
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_addr;
    logic [7:0]            fwd_data;
`endif

    // Wraps modulo 2^REG_ADDR_W, so dest 31 pairs with register 0.
    assign dest_inc = dest_q + ADDR_ONE;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q <= IDLE;
            prod_q  <= '0;
            flags_q <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                prod_q  <= bus.mult_out;
                flags_q <= bus.flags_in;
                dest_q  <= bus.dest_reg;
            end
        end
    end

    // Outputs depend only on state and latched data, so start cannot glitch rf_we.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        flags_we  = 1'b0;
        flags_out = '0;
        done      = 1'b0;
`ifdef MULT_WB_FWD_EN
        fwd_valid = 1'b0;
        fwd_addr  = '0;
        fwd_data  = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = WR_LO;
            end
            WR_LO: begin
                state_d  = WR_HI;
                busy     = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = dest_q;
                rf_wdata = prod_q[7:0];
`ifdef MULT_WB_FWD_EN
                fwd_valid = 1'b1;
                fwd_addr  = dest_inc;
                fwd_data  = prod_q[15:8];
`endif
            end
            WR_HI: begin
                state_d   = IDLE;
                busy      = 1'b1;
                rf_we     = 1'b1;
                rf_waddr  = dest_inc;
                rf_wdata  = prod_q[15:8];
                flags_we  = 1'b1;
                flags_out = flags_q;
                done      = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = busy;
    assign bus.rf_we     = rf_we;
    assign bus.rf_waddr  = rf_waddr;
    assign bus.rf_wdata  = rf_wdata;
    assign bus.flags_we  = flags_we;
    assign bus.flags_out = flags_out;
    assign bus.done      = done;
`ifdef MULT_WB_FWD_EN
    assign bus.fwd_valid = fwd_valid;
    assign bus.fwd_addr  = fwd_addr;
    assign bus.fwd_data  = fwd_data;
`endif
endmodule
